// File: rtl/mod_config_scheduler.sv
// mod_config_scheduler
// Stages host writes of the modulation cycle length, update period and buffer
// bank into shadow registers, and applies them atomically at an update-period
// boundary (tick mode) or at the next SYNC pulse (sync mode). Also owns the
// period counter that produces the UPDATE_TICK the sampler advances on.
//
// Register map (CPU_WE is a one-cycle strobe):
//   0 : MOD_CYCLE shadow
//   1 : UPDATE_CYCLE[15:0] shadow
//   2 : UPDATE_CYCLE[31:16] shadow
//   3 : commit  (CPU_DATA[0] = target bank, CPU_DATA[1] = apply on SYNC)
//
// Writes are honoured only while no commit is outstanding; anything written
// while PENDING is dropped and latches the sticky WR_ERR flag.

module mod_config_scheduler #(
  parameter logic [15:0] MOD_CYCLE_RST    = 16'd4000,
  parameter logic [31:0] UPDATE_CYCLE_RST = 32'd40960,
  parameter logic [31:0] UPDATE_CYCLE_MIN = 32'd16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_ADDR,
  input  logic [15:0] CPU_DATA,
  input  logic        SYNC,
  output logic [15:0] MOD_CYCLE,
  output logic [31:0] UPDATE_CYCLE,
  output logic        BANK_SEL,
  output logic        UPDATE_TICK,
  output logic        PENDING,
  output logic        APPLIED,
  output logic        WR_ERR,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PEND_TICK = 2'd1,
    ST_PEND_SYNC = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MOD    = 2'd0;
  localparam logic [1:0] ADDR_UPD_LO = 2'd1;
  localparam logic [1:0] ADDR_UPD_HI = 2'd2;
  localparam logic [1:0] ADDR_COMMIT = 2'd3;

  state_t      state;
  logic [31:0] cnt;

  // Shadow registers and the bank latched by the last accepted commit.
  logic [15:0] mod_sh;
  logic [31:0] upd_sh;
  logic        bank_sh;

  // Combinational decode of the current cycle.
  logic        boundary;
  logic        apply_now;
  logic        wr_shadow;
  logic        wr_commit;
  logic        wr_reject;
  logic [31:0] upd_clamped;
  logic [15:0] mod_clamped;

  // Decode boundary, apply and write acceptance for this cycle.
  always_comb begin
    boundary    = 1'b0;
    apply_now   = 1'b0;
    wr_shadow   = 1'b0;
    wr_commit   = 1'b0;
    wr_reject   = 1'b0;
    upd_clamped = upd_sh;
    mod_clamped = mod_sh;

    // The >= keeps the counter from ever running past the period even if
    // UPDATE_CYCLE were to shrink under a running count; an apply always
    // restarts the count at 0, so in practice only the == case fires.
    boundary = (cnt >= (UPDATE_CYCLE - 32'd1)) || SYNC;

    // Tick-mode commits apply on any boundary (a SYNC counts as one);
    // sync-mode commits ignore ordinary ticks and wait for SYNC itself.
    apply_now = ((state == ST_PEND_TICK) && boundary) ||
                ((state == ST_PEND_SYNC) && SYNC);

    wr_shadow = CPU_WE && (state == ST_IDLE) && (CPU_ADDR != ADDR_COMMIT);
    wr_commit = CPU_WE && (state == ST_IDLE) && (CPU_ADDR == ADDR_COMMIT);
    wr_reject = CPU_WE && (state != ST_IDLE);

    if (upd_sh < UPDATE_CYCLE_MIN) begin
      upd_clamped = UPDATE_CYCLE_MIN;
    end
    if (mod_sh == 16'd0) begin
      mod_clamped = 16'd1;
    end
  end

  // Period counter: restarts at every boundary and flags the tick one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= 32'd0;
      UPDATE_TICK <= 1'b0;
    end else begin
      UPDATE_TICK <= boundary;
      if (boundary) begin
        cnt <= 32'd0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Shadow registers: loaded from the bus only while no commit is outstanding.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mod_sh  <= MOD_CYCLE_RST;
      upd_sh  <= UPDATE_CYCLE_RST;
      bank_sh <= 1'b0;
    end else begin
      if (wr_shadow) begin
        case (CPU_ADDR)
          ADDR_MOD:    mod_sh         <= CPU_DATA;
          ADDR_UPD_LO: upd_sh[15:0]   <= CPU_DATA;
          ADDR_UPD_HI: upd_sh[31:16]  <= CPU_DATA;
          default:     mod_sh         <= mod_sh;
        endcase
      end
      if (wr_commit) begin
        bank_sh <= CPU_DATA[0];
      end
    end
  end

  // Commit FSM: holds a pending commit and loads the active registers on apply.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      MOD_CYCLE    <= MOD_CYCLE_RST;
      UPDATE_CYCLE <= UPDATE_CYCLE_RST;
      BANK_SEL     <= 1'b0;
      PENDING      <= 1'b0;
      APPLIED      <= 1'b0;
      WR_ERR       <= 1'b0;
    end else begin
      APPLIED <= 1'b0;

      // Sticky: any write while a commit is outstanding, including a
      // second commit, is dropped and remembered until reset.
      if (wr_reject) begin
        WR_ERR <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // A commit that lands on a boundary cycle only arms the FSM here;
          // the apply is evaluated from the pending state, so it waits for
          // the following boundary.
          if (wr_commit) begin
            PENDING <= 1'b1;
            if (CPU_DATA[1]) begin
              state <= ST_PEND_SYNC;
            end else begin
              state <= ST_PEND_TICK;
            end
          end
        end

        ST_PEND_TICK, ST_PEND_SYNC: begin
          // Same edge as the counter restart, so the new period counts
          // from 0 and a shrinking period can never strand cnt above it.
          if (apply_now) begin
            MOD_CYCLE    <= mod_clamped;
            UPDATE_CYCLE <= upd_clamped;
            BANK_SEL     <= bank_sh;
            APPLIED      <= 1'b1;
            PENDING      <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: begin
          PENDING <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_mod_config_scheduler.sv
// Bench for mod_config_scheduler: directed scenarios plus a randomized phase,
// all checked against a cycle-level reference model of the scheduling rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_mod_config_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CPU_WE = 1'b0;
  logic [1:0]  CPU_ADDR = 2'd0;
  logic [15:0] CPU_DATA = 16'd0;
  logic        SYNC = 1'b0;
  logic [15:0] MOD_CYCLE;
  logic [31:0] UPDATE_CYCLE;
  logic        BANK_SEL;
  logic        UPDATE_TICK;
  logic        PENDING;
  logic        APPLIED;
  logic        WR_ERR;
  logic [1:0]  DBG_STATE;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model state: active values, shadows and the time since the
  // last period start, updated once per clock from the spec's rules.
  logic [31:0] m_phase, m_uc, sh_uc;
  logic [15:0] m_mc, sh_mc;
  logic        m_bank, sh_bank, m_pend, m_sync_mode, m_err;
  logic        exp_tick, exp_applied;

  mod_config_scheduler dut (
    .CLK          (CLK),
    .RST          (RST),
    .CPU_WE       (CPU_WE),
    .CPU_ADDR     (CPU_ADDR),
    .CPU_DATA     (CPU_DATA),
    .SYNC         (SYNC),
    .MOD_CYCLE    (MOD_CYCLE),
    .UPDATE_CYCLE (UPDATE_CYCLE),
    .BANK_SEL     (BANK_SEL),
    .UPDATE_TICK  (UPDATE_TICK),
    .PENDING      (PENDING),
    .APPLIED      (APPLIED),
    .WR_ERR       (WR_ERR),
    .DBG_STATE    (DBG_STATE)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_phase = 32'd0;  m_uc = 32'd40960; sh_uc = 32'd40960;
    m_mc = 16'd4000;  sh_mc = 16'd4000;
    m_bank = 1'b0;    sh_bank = 1'b0;
    m_pend = 1'b0;    m_sync_mode = 1'b0; m_err = 1'b0;
    exp_tick = 1'b0;  exp_applied = 1'b0;
  endtask

  // One clock of the reference model, using the inputs currently driven.
  task automatic model_update();
    logic bnd, app, was_pend;
    bnd      = (m_phase == m_uc - 32'd1) || SYNC;
    was_pend = m_pend;
    app      = m_pend && (m_sync_mode ? SYNC : bnd);
    exp_tick    = bnd;
    exp_applied = app;
    m_phase = bnd ? 32'd0 : m_phase + 32'd1;
    if (app) begin
      m_uc   = (sh_uc < 32'd16) ? 32'd16 : sh_uc;
      m_mc   = (sh_mc == 16'd0) ? 16'd1 : sh_mc;
      m_bank = sh_bank;
      m_pend = 1'b0;
    end
    if (CPU_WE) begin
      if (was_pend) m_err = 1'b1;
      else begin
        case (CPU_ADDR)
          2'd0: sh_mc = CPU_DATA;
          2'd1: sh_uc[15:0] = CPU_DATA;
          2'd2: sh_uc[31:16] = CPU_DATA;
          default: begin
            m_pend = 1'b1;
            m_sync_mode = CPU_DATA[1];
            sh_bank = CPU_DATA[0];
          end
        endcase
      end
    end
  endtask

  // Driver tasks: always entered and left on a falling edge.
  task automatic step();
    model_update();
    @(negedge CLK);
    cyc++;
    CPU_WE = 1'b0;
    SYNC   = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [15:0] data);
    CPU_WE = 1'b1; CPU_ADDR = addr; CPU_DATA = data;
    step();
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    #1;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
  endtask

  // Steps until UPDATE_TICK is seen; returns steps taken, or -1 on timeout.
  task automatic wait_tick(input int limit, output int steps, output int applied_seen);
    steps = -1;
    applied_seen = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (APPLIED) applied_seen++;
      if (UPDATE_TICK) begin
        steps = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({MOD_CYCLE, UPDATE_CYCLE, BANK_SEL} !== {16'd4000, 32'd40960, 1'b0})
      $display("FAIL reset_active: got mod=%0d upd=%0d bank=%0d want 4000 40960 0", MOD_CYCLE, UPDATE_CYCLE, BANK_SEL);
    else n_pass++;
    n_total++;
    if ({UPDATE_TICK, PENDING, APPLIED, WR_ERR} !== 4'b0000)
      $display("FAIL reset_flags: got tick/pend/appl/err=%b want 0000", {UPDATE_TICK, PENDING, APPLIED, WR_ERR});
    else n_pass++;
  endtask

  task automatic test_idle_period();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 40000; i++) begin
      step();
      if (UPDATE_TICK) ticks++;
    end
    n_total++;
    if (ticks !== 0) $display("FAIL idle_no_early_tick: got %0d ticks want 0", ticks);
    else n_pass++;
    n_total++;
    if ({MOD_CYCLE, BANK_SEL} !== {16'd4000, 1'b0})
      $display("FAIL idle_values: got mod=%0d bank=%0d want 4000 0", MOD_CYCLE, BANK_SEL);
    else n_pass++;
  endtask

  task automatic test_commit_tick();
    int steps, appl;
    cpu_write(2'd0, 16'd100);
    cpu_write(2'd1, 16'h0400);
    cpu_write(2'd2, 16'h0000);
    cpu_write(2'd3, 16'h0001);
    n_total++;
    if (PENDING !== 1'b1) $display("FAIL commit_pending_rise: got %b want 1", PENDING);
    else n_pass++;
    wait_tick(2000, steps, appl);
    n_total++;
    if (cyc !== 40960) $display("FAIL reset_period: first tick at cycle %0d want 40960", cyc);
    else n_pass++;
    n_total++;
    if ({APPLIED, PENDING, MOD_CYCLE, UPDATE_CYCLE, BANK_SEL} !== {1'b1, 1'b0, 16'd100, 32'd1024, 1'b1})
      $display("FAIL tick_apply: got appl=%b pend=%b mod=%0d upd=%0d bank=%b want 1 0 100 1024 1",
               APPLIED, PENDING, MOD_CYCLE, UPDATE_CYCLE, BANK_SEL);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      wait_tick(2000, steps, appl);
      n_total++;
      if (steps !== 1024 || appl !== 0)
        $display("FAIL period_1024: got interval %0d applied %0d want 1024 0", steps, appl);
      else n_pass++;
    end
  endtask

  task automatic test_sync_commit();
    int steps, appl, total_appl, n;
    cpu_write(2'd3, 16'h0002);
    total_appl = 0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(2000, steps, appl);
      total_appl += appl;
    end
    n_total++;
    if (total_appl !== 0 || PENDING !== 1'b1 || BANK_SEL !== 1'b1)
      $display("FAIL sync_hold: got applied=%0d pend=%b bank=%b want 0 1 1", total_appl, PENDING, BANK_SEL);
    else n_pass++;
    for (int i = 0; i < 100; i++) step();
    SYNC = 1'b1;
    step();
    n_total++;
    if ({UPDATE_TICK, APPLIED, PENDING, BANK_SEL} !== 4'b1100)
      $display("FAIL sync_apply: got tick/appl/pend/bank=%b want 1100", {UPDATE_TICK, APPLIED, PENDING, BANK_SEL});
    else n_pass++;
    step();
    n = 1;
    n_total++;
    if (UPDATE_TICK !== 1'b0) $display("FAIL sync_single_tick: got %b want 0", UPDATE_TICK);
    else n_pass++;
    wait_tick(2000, steps, appl);
    n_total++;
    if (steps + n !== 1024) $display("FAIL sync_restart: got interval %0d want 1024", steps + n);
    else n_pass++;
  endtask

  task automatic test_wr_err();
    int steps, appl;
    cpu_write(2'd3, 16'h0001);
    cpu_write(2'd0, 16'd5);
    n_total++;
    if (WR_ERR !== 1'b1) $display("FAIL wr_err_set: got %b want 1", WR_ERR);
    else n_pass++;
    cpu_write(2'd3, 16'h0000);
    wait_tick(2000, steps, appl);
    n_total++;
    if ({APPLIED, MOD_CYCLE, BANK_SEL, WR_ERR} !== {1'b1, 16'd100, 1'b1, 1'b1})
      $display("FAIL wr_err_dropped: got appl=%b mod=%0d bank=%b err=%b want 1 100 1 1",
               APPLIED, MOD_CYCLE, BANK_SEL, WR_ERR);
    else n_pass++;
  endtask

  task automatic test_clamp();
    int steps, appl;
    cpu_write(2'd0, 16'd0);
    cpu_write(2'd1, 16'd3);
    cpu_write(2'd2, 16'd0);
    cpu_write(2'd3, 16'h0000);
    wait_tick(2000, steps, appl);
    n_total++;
    if ({APPLIED, UPDATE_CYCLE, MOD_CYCLE, BANK_SEL} !== {1'b1, 32'd16, 16'd1, 1'b0})
      $display("FAIL clamp_apply: got appl=%b upd=%0d mod=%0d bank=%b want 1 16 1 0",
               APPLIED, UPDATE_CYCLE, MOD_CYCLE, BANK_SEL);
    else n_pass++;
    wait_tick(100, steps, appl);
    n_total++;
    if (steps !== 16) $display("FAIL clamp_period: got interval %0d want 16", steps);
    else n_pass++;
  endtask

  task automatic test_boundary_cases();
    int steps, appl;
    // SYNC landing on the tick cycle: one boundary, one tick.
    for (int i = 0; i < 15; i++) step();
    SYNC = 1'b1;
    step();
    n_total++;
    if (UPDATE_TICK !== 1'b1) $display("FAIL coincide_tick: got %b want 1", UPDATE_TICK);
    else n_pass++;
    wait_tick(100, steps, appl);
    n_total++;
    if (steps !== 16) $display("FAIL coincide_single: got interval %0d want 16", steps);
    else n_pass++;
    // Commit sampled on a boundary cycle waits for the next boundary.
    for (int i = 0; i < 15; i++) step();
    cpu_write(2'd3, 16'h0001);
    n_total++;
    if ({UPDATE_TICK, APPLIED, PENDING} !== 3'b101)
      $display("FAIL commit_on_boundary: got tick/appl/pend=%b want 101", {UPDATE_TICK, APPLIED, PENDING});
    else n_pass++;
    wait_tick(100, steps, appl);
    n_total++;
    if (steps !== 16 || APPLIED !== 1'b1 || BANK_SEL !== 1'b1)
      $display("FAIL commit_next_boundary: got interval %0d appl=%b bank=%b want 16 1 1", steps, APPLIED, BANK_SEL);
    else n_pass++;
  endtask

  task automatic test_reset_pending();
    int appl;
    cpu_write(2'd3, 16'h0000);
    step();
    step();
    n_total++;
    if (PENDING !== 1'b1) $display("FAIL rst_pending_pre: got %b want 1", PENDING);
    else n_pass++;
    RST = 1'b1;
    #1;
    n_total++;
    if ({MOD_CYCLE, UPDATE_CYCLE, BANK_SEL, UPDATE_TICK, PENDING, APPLIED, WR_ERR} !==
        {16'd4000, 32'd40960, 1'b0, 4'b0000})
      $display("FAIL rst_async: got mod=%0d upd=%0d bank=%b tick/pend/appl/err=%b want 4000 40960 0 0000",
               MOD_CYCLE, UPDATE_CYCLE, BANK_SEL, {UPDATE_TICK, PENDING, APPLIED, WR_ERR});
    else n_pass++;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    appl = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (APPLIED || PENDING) appl++;
    end
    n_total++;
    if (appl !== 0) $display("FAIL rst_discard: got %0d cycles with applied/pending want 0", appl);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad, r;
    logic [1:0] a;
    logic [15:0] d;
    cpu_write(2'd1, 16'($urandom_range(0, 40)));
    cpu_write(2'd2, 16'd0);
    cpu_write(2'd3, 16'($urandom_range(0, 3)));
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        a = 2'($urandom_range(0, 2));
        if (a == 2'd0) d = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        else if (a == 2'd1) d = 16'($urandom_range(0, 60));
        else d = 16'd0;
        CPU_WE = 1'b1; CPU_ADDR = a; CPU_DATA = d;
      end else if (r < 10) begin
        CPU_WE = 1'b1; CPU_ADDR = 2'd3; CPU_DATA = 16'($urandom_range(0, 3));
      end
      SYNC = ($urandom_range(0, 29) == 0);
      step();
      n_total++;
      if ({MOD_CYCLE, UPDATE_CYCLE, BANK_SEL, UPDATE_TICK, PENDING, APPLIED, WR_ERR} !==
          {m_mc, m_uc, m_bank, exp_tick, m_pend, exp_applied, m_err}) begin
        if (bad < 10)
          $display("FAIL random_cycle %0d: got mod=%0d upd=%0d bank/tick/pend/appl/err=%b want mod=%0d upd=%0d %b",
                   i, MOD_CYCLE, UPDATE_CYCLE, {BANK_SEL, UPDATE_TICK, PENDING, APPLIED, WR_ERR},
                   m_mc, m_uc, {m_bank, exp_tick, m_pend, exp_applied, m_err});
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_period();
    test_commit_tick();
    test_sync_commit();
    test_wr_err();
    test_clamp();
    test_boundary_cases();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
